// File: rtl/send_buffer.sv
// rtl/send_buffer.sv - 2-entry skid buffer with registered in_ready, sync flush and drain counter
module send_buffer #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] sent_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  main_q, main_d;
  logic [N-1:0]  skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (accept && drain) begin
          main_d = in_data;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush discards any word accepted this cycle; a drain still completes.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
    cnt_d       = cnt_q + {{(CW-1){1'b0}}, drain};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = main_q;
  assign sent_count = cnt_q;

endmodule

// File: tb/tb_send_buffer.sv
// tb/tb_send_buffer.sv - directed vector bench for send_buffer (default and CW=4 instances)
module tb_send_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready,  out_valid;
  logic [31:0] out_data;
  logic [15:0] sent_count;

  logic        in_ready4, out_valid4;
  logic [31:0] out_data4;
  logic [3:0]  sent_count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  send_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sent_count(sent_count)
  );

  send_buffer #(.N(32), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .sent_count(sent_count4)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        eov;
    logic [31:0] eod;
    logic        eir;
    int          ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                     input logic eov, input logic [31:0] eod, input logic eir, input int ecnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eir = eir; v.ecnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  task automatic check_outputs(input string tag, input logic eov, input logic [31:0] eod,
                               input logic eir, input int ecnt);
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, eov});
    if (eov) chk({tag, " out_data"}, out_data, eod);
    chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, eir});
    chk({tag, " sent_count"}, {16'd0, sent_count}, ecnt & 32'hFFFF);
    chk({tag, " sent_count4"}, {28'd0, sent_count4}, ecnt & 32'hF);
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset sent_count", {16'd0, sent_count}, 32'd0);

    rst = 1'b0;
    #2;
    chk("in_ready before first edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("in_ready after first edge", {31'd0, in_ready}, 32'd1);

    // fl iv data ordy | out_valid out_data in_ready count
    add(0, 1, 32'hA5, 1,  1, 32'hA5, 1, 1 - 1);
    add(0, 0, 32'h00, 1,  0, 32'hA5, 1, 1);
    add(0, 1, 32'h10, 1,  1, 32'h10, 1, 1);
    add(0, 1, 32'h11, 1,  1, 32'h11, 1, 2);
    add(0, 1, 32'h12, 1,  1, 32'h12, 1, 3);
    add(0, 1, 32'h13, 1,  1, 32'h13, 1, 4);
    add(0, 1, 32'h14, 1,  1, 32'h14, 1, 5);
    add(0, 1, 32'h15, 1,  1, 32'h15, 1, 6);
    add(0, 1, 32'h16, 1,  1, 32'h16, 1, 7);
    add(0, 1, 32'h17, 1,  1, 32'h17, 1, 8);
    add(0, 0, 32'h00, 1,  0, 32'h17, 1, 9);
    add(0, 1, 32'h01, 0,  1, 32'h01, 1, 9);
    add(0, 1, 32'h02, 0,  1, 32'h01, 0, 9);
    add(0, 1, 32'h99, 0,  1, 32'h01, 0, 9);
    add(0, 0, 32'h00, 1,  1, 32'h02, 1, 10);
    add(0, 0, 32'h00, 1,  0, 32'h02, 1, 11);
    add(0, 1, 32'h03, 0,  1, 32'h03, 1, 11);
    add(0, 1, 32'h04, 1,  1, 32'h04, 1, 12);
    add(0, 0, 32'h00, 0,  1, 32'h04, 1, 12);
    add(0, 0, 32'h00, 1,  0, 32'h04, 1, 13);
    add(0, 1, 32'h05, 0,  1, 32'h05, 1, 13);
    add(0, 1, 32'h06, 0,  1, 32'h05, 0, 13);
    add(1, 1, 32'h07, 1,  0, 32'h05, 1, 14);
    add(0, 0, 32'h00, 1,  0, 32'h05, 1, 14);
    add(1, 1, 32'h08, 0,  0, 32'h05, 1, 14);
    add(0, 0, 32'h00, 0,  0, 32'h05, 1, 14);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].fl, vq[i].iv, vq[i].d, vq[i].ordy);
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", i), vq[i].eov, vq[i].eod, vq[i].eir, vq[i].ecnt);
    end
    chk("flushed out_data not exposed", out_data, 32'h05);

    // Long stream crosses the CW=4 wrap twice (drain counts 16 and 32).
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 32'h100 + i, 1'b1);
      @(posedge clk); #1;
      check_outputs($sformatf("stream%0d", i), 1'b1, 32'h100 + i, 1'b1, 14 + i);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    check_outputs("stream end", 1'b0, 32'h0, 1'b1, 34);
    chk("wrap cw4 value", {28'd0, sent_count4}, 32'd2);

    // Asynchronous reset while a word is held.
    drive(1'b0, 1'b1, 32'hBEEF, 1'b0);
    @(posedge clk); #1;
    check_outputs("pre-reset", 1'b1, 32'hBEEF, 1'b1, 34);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("async rst out_data", out_data, 32'd0);
    chk("async rst sent_count", {16'd0, sent_count}, 32'd0);
    chk("async rst sent_count4", {28'd0, sent_count4}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post-rst in_ready low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check_outputs("post-rst", 1'b0, 32'h0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/send_buffer.md
Name: send_buffer

Overview:
- Transmit-side stage for inter-stage word transfer in the RV32 core. Producer words enter on a valid/ready handshake and are presented to a downstream receiving register stage.
- A 2-entry skid buffer keeps throughput at 1 word/cycle. in_ready is registered, so there is no combinational path from out_ready.
- Supports synchronous flush (pipeline kill on branch/trap) and counts completed transfers.

Parameters:
N, 32, data word width
CW, 16, width of sent-word counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous kill; discards all buffered words
in_valid  input  1  producer offers in_data
in_ready  output  1  buffer can accept a word this cycle (registered)
in_data  input  N  producer word
out_valid  output  1  out_data holds a valid word
out_ready  input  1  receiver takes out_data this cycle
out_data  output  N  head word (main register)
sent_count  output  CW  number of completed downstream transfers, wraps

Behaviour:
- Reset: one clock (clk); reset (rst) is asynchronous and active-high.
  - While rst is high: state=EMPTY, main=0, skid=0, out_data=0, out_valid=0, in_ready=0, sent_count=0.
  - in_ready rises on the first clk edge after rst deasserts.
  - Reset mid-transfer drops all words immediately, with no count.
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- States:
  - EMPTY: 0 words.
  - ONE: main valid.
  - TWO: main and skid valid.
- Outputs:
  - out_valid = (state != EMPTY).
  - out_data = main.
- Transitions, when flush=0:
  - EMPTY: accept -> ONE, main<=in_data.
  - ONE:
    - accept & !drain -> TWO, skid<=in_data.
    - accept & drain -> ONE, main<=in_data.
    - !accept & drain -> EMPTY.
    - else hold.
  - TWO:
    - drain -> ONE, main<=skid.
    - else hold. accept cannot occur because in_ready=0.
- in_ready register: next value = (next_state != TWO). It is 1 in EMPTY/ONE and 0 in TWO.
- Word order: strict FIFO. Latency from accept in EMPTY to out_valid is 1 cycle.
- Hold rule: while out_valid=1 and out_ready=0, out_data and out_valid are stable.
- Once in_ready=1 is offered it is not withdrawn until an accept or a flush occurs.
- Flush has highest priority:
  - next state=EMPTY, in_ready next=1, main/skid contents don't-care (kept unchanged).
  - A word accepted in the flush cycle is discarded.
  - A drain in the flush cycle completes: the receiver latched the word, so it is counted.
- sent_count:
  - Increments by 1 on every drain, including a drain in the flush cycle.
  - Wraps 2^CW-1 -> 0.
  - Unaffected by flush.
- out_ready is permitted while out_valid=0 and has no effect.

Test Plan:
- Reset then single word: rst 1->0; cycle 1 in_valid=1, in_data=0x0000_00A5, out_ready=1 -> out_valid=1 with out_data=0x0000_00A5 next cycle; following cycle out_valid=0, sent_count=1.
- Back-to-back streaming: 8 words 0x10..0x17 with out_ready=1 every cycle -> in_ready stays 1, one word output per cycle in order, sent_count=8.
- Backpressure/skid: out_ready=0, push 0x1 then 0x2 -> state TWO, in_ready=0, out_data held 0x1. Then out_ready=1 -> 0x1 then 0x2 out in order, in_ready=1 one cycle after first drain.
- Simultaneous accept+drain in ONE: main=0x3, in_data=0x4, in_valid=out_ready=1 -> next out_data=0x4, state ONE, sent_count +1.
- Flush: state TWO holding 0x5,0x6, assert flush with out_ready=1 and in_valid=1 (0x7) -> next cycle out_valid=0, in_ready=1, sent_count +1 (0x5), 0x6 and 0x7 never appear.
- Counter wrap and async reset: CW=4, 16 drains -> sent_count=0. Assert rst asynchronously between edges while out_valid=1 -> out_valid=0, in_ready=0 immediately, without waiting for an edge.
